// File: rtl/adder_pkg.sv
// Shared types and helpers for the ripple-carry adder slice.
// Status-flag fields exist only when ADDER_STATUS_FLAGS_EN is defined.
package adder_pkg;

  localparam int unsigned ADDER_WIDTH_DEFAULT = 4;

  // Flag group kept separate from the sum so it is independent of WIDTH.
  typedef struct packed {
    logic cout;
    logic overflow;
`ifdef ADDER_STATUS_FLAGS_EN
    logic zero;
    logic negative;
`endif
  } adder_flags_t;

  typedef struct packed {
    logic [ADDER_WIDTH_DEFAULT-1:0] sum;
    adder_flags_t                   flags;
  } adder_result_t;

  // Signed overflow: carry into the MSB differs from carry out of it.
  function automatic logic adder_overflow(input logic c_out_msb, input logic c_in_msb);
    return c_out_msb ^ c_in_msb;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder cell; chained by full_adder_4b into a ripple-carry adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  always_comb begin
    p    = a ^ b;
    s    = p ^ cin;
    cout = (a & b) | (cin & p);
  end

endmodule

// File: rtl/full_adder_4b.sv
// WIDTH-bit ripple-carry adder with combinational and one-stage registered results.
// Optional status flags (zero/negative) are enabled by ADDER_STATUS_FLAGS_EN.
module full_adder_4b
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             overflow_q,
`ifdef ADDER_STATUS_FLAGS_EN
  output logic             zero,
  output logic             negative,
  output logic             zero_q,
  output logic             negative_q,
`endif
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    fa_cell u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  adder_flags_t     flags;
  adder_flags_t     flags_d, flags_q;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_reg_q;
  logic             out_valid_d, out_valid_q;

  always_comb begin
    flags          = '0;
    flags.cout     = c[WIDTH];
    flags.overflow = adder_overflow(c[WIDTH], c[WIDTH-1]);
`ifdef ADDER_STATUS_FLAGS_EN
    flags.zero     = (s == '0);
    flags.negative = s[WIDTH-1];
`endif
  end

  always_comb begin
    sum_d       = sum_reg_q;
    flags_d     = flags_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      sum_d   = s;
      flags_d = flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg_q   <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sum_reg_q   <= sum_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum        = s;
  assign cout       = flags.cout;
  assign overflow   = flags.overflow;
  assign sum_q      = sum_reg_q;
  assign cout_q     = flags_q.cout;
  assign overflow_q = flags_q.overflow;
  assign out_valid  = out_valid_q;
`ifdef ADDER_STATUS_FLAGS_EN
  assign zero       = flags.zero;
  assign negative   = flags.negative;
  assign zero_q     = flags_q.zero;
  assign negative_q = flags_q.negative;
`endif

endmodule

// File: tb/tb_full_adder_4b.sv
// Directed and exhaustive self-checking bench for full_adder_4b (WIDTH=4).
// Status-flag checks are compiled in when ADDER_STATUS_FLAGS_EN is defined.
module tb_full_adder_4b;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a, b;
  logic       cin, in_valid;
  logic [3:0] sum, sum_q;
  logic       cout, overflow, cout_q, overflow_q, out_valid;
`ifdef ADDER_STATUS_FLAGS_EN
  logic       zero, negative, zero_q, negative_q;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  full_adder_4b #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .in_valid   (in_valid),
    .sum        (sum),
    .cout       (cout),
    .overflow   (overflow),
    .sum_q      (sum_q),
    .cout_q     (cout_q),
    .overflow_q (overflow_q),
`ifdef ADDER_STATUS_FLAGS_EN
    .zero       (zero),
    .negative   (negative),
    .zero_q     (zero_q),
    .negative_q (negative_q),
`endif
    .out_valid  (out_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one vector, check combinational outputs, then registered outputs after the edge.
  task automatic apply_vec(input string tag, input logic [3:0] va, input logic [3:0] vb,
                           input logic vc, input logic [3:0] es, input logic ec,
                           input logic eo);
    @(negedge clk);
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    #1;
    check({tag, ".sum"}, 32'(sum), 32'(es));
    check({tag, ".cout"}, 32'(cout), 32'(ec));
    check({tag, ".ovf"}, 32'(overflow), 32'(eo));
    @(posedge clk);
    #1;
    check({tag, ".sum_q"}, 32'(sum_q), 32'(es));
    check({tag, ".cout_q"}, 32'(cout_q), 32'(ec));
    check({tag, ".ovf_q"}, 32'(overflow_q), 32'(eo));
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    logic [4:0] ref_full;
    logic       ref_ovf;

    rst_n = 1'b0; in_valid = 1'b0;
    a = 4'b0001; b = 4'b0001; cin = 1'b0;
    #2;
    check("rst.sum_q", 32'(sum_q), 32'd0);
    check("rst.cout_q", 32'(cout_q), 32'd0);
    check("rst.ovf_q", 32'(overflow_q), 32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.comb_sum", 32'(sum), 32'h2);
    @(negedge clk);
    rst_n = 1'b1;

    apply_vec("v1",  4'b0001, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b0);
    apply_vec("v2",  4'b0001, 4'b0001, 1'b1, 4'b0011, 1'b0, 1'b0);
    apply_vec("v3",  4'b0011, 4'b0101, 1'b0, 4'b1000, 1'b0, 1'b1);
    apply_vec("v4",  4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);
    apply_vec("v5",  4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b0);
    apply_vec("v6",  4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0);
    apply_vec("v7",  4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1);
    apply_vec("v8",  4'b0111, 4'b1001, 1'b0, 4'b0000, 1'b1, 1'b0);
`ifdef ADDER_STATUS_FLAGS_EN
    check("v8.zero", 32'(zero), 32'd1);
    check("v8.negative", 32'(negative), 32'd0);
    check("v8.zero_q", 32'(zero_q), 32'd1);
    check("v8.negative_q", 32'(negative_q), 32'd0);
`endif

    // Capture a pulse, then hold for three idle cycles with changing inputs.
    apply_vec("pulse", 4'b0011, 4'b0101, 1'b0, 4'b1000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      a = 4'(i + 1); b = 4'(i * 3); cin = i[0];
      @(posedge clk);
      #1;
      check("hold.sum_q", 32'(sum_q), 32'h8);
      check("hold.ovf_q", 32'(overflow_q), 32'd1);
      check("hold.cout_q", 32'(cout_q), 32'd0);
      check("hold.out_valid", 32'(out_valid), 32'd0);
    end

    // Mid-stream reset between edges clears everything without a clock.
    apply_vec("pre_rst", 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0);
    @(negedge clk);
    a = 4'b1000; b = 4'b1000; cin = 1'b0; in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.sum_q", 32'(sum_q), 32'd0);
    check("arst.cout_q", 32'(cout_q), 32'd0);
    check("arst.ovf_q", 32'(overflow_q), 32'd0);
    check("arst.out_valid", 32'(out_valid), 32'd0);
    check("arst.comb_sum", 32'(sum), 32'd0);
    check("arst.comb_cout", 32'(cout), 32'd1);
    @(posedge clk);
    #1;
    check("arst_edge.sum_q", 32'(sum_q), 32'd0);
    check("arst_edge.out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_vec("post_rst", 4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1);

    // Exhaustive sweep against the arithmetic reference and the sign-based overflow rule.
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      a = 4'(i >> 5); b = 4'(i >> 1); cin = i[0]; in_valid = 1'b1;
      ref_full = 5'(a) + 5'(b) + 5'(cin);
      ref_ovf  = (a[3] == b[3]) && (ref_full[3] != a[3]);
      #1;
      check("sweep.sum", 32'({cout, sum}), 32'(ref_full));
      check("sweep.ovf", 32'(overflow), 32'(ref_ovf));
`ifdef ADDER_STATUS_FLAGS_EN
      check("sweep.zero", 32'(zero), 32'(ref_full[3:0] == 4'd0));
      check("sweep.neg", 32'(negative), 32'(ref_full[3]));
`endif
      @(posedge clk);
      #1;
      check("sweep.sum_q", 32'({cout_q, sum_q}), 32'(ref_full));
      check("sweep.ovf_q", 32'(overflow_q), 32'(ref_ovf));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/full_adder_4b.md
Name: full_adder_4b

Overview:
- Two's-complement/unsigned 4-bit adder with carry-in. Produces sum, carry-out and signed-overflow flags.
- Results are available combinationally (zero latency) and also registered through one pipeline stage with a valid qualifier.
- Used as the arithmetic leaf in datapath ALUs. Downstream logic picks either the combinational outputs or the registered ones.

Parameters:
- WIDTH, 4, operand/sum width. Spec and tests are written for 4; RTL must be generic for WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock for the output register stage
- rst_n  input  1  asynchronous active-low reset; clears the register stage
- a  input  WIDTH  operand A (unsigned or two's complement)
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- in_valid  input  1  qualifies a/b/cin for capture into the register stage
- sum  output  WIDTH  combinational sum, low WIDTH bits of a+b+cin
- cout  output  1  combinational carry-out of the MSB
- overflow  output  1  combinational signed overflow
- sum_q  output  WIDTH  registered sum
- cout_q  output  1  registered cout
- overflow_q  output  1  registered overflow
- out_valid  output  1  registered in_valid

Behaviour:
- Carry chain: ripple-carry of WIDTH 1-bit full-adder cells.
  - c[0] = cin
  - s[i] = a[i]^b[i]^c[i]
  - c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i])
- Outputs of the chain:
  - cout = c[WIDTH]
  - overflow = c[WIDTH] ^ c[WIDTH-1], i.e. both operands have the same sign and the sum sign differs.
- {cout,sum} must equal a+b+cin exactly for all 2^(2*WIDTH+1) input combinations.
- Combinational outputs:
  - No clock dependency.
  - Valid whenever inputs are stable.
  - Unaffected by rst_n.
- Register stage, on rising clk:
  - If in_valid=1: sum_q/cout_q/overflow_q capture the current combinational results.
  - If in_valid=0: sum_q/cout_q/overflow_q hold their previous values.
  - out_valid <= in_valid on every edge.
  - Latency is 1 cycle.
- Reset: rst_n low asynchronously forces sum_q=0, cout_q=0, overflow_q=0, out_valid=0, independent of clk.
  - Reset deassertion is synchronised by the system.
  - The first capture happens at the first rising edge with rst_n high.
  - Reset asserted mid-stream discards the pending result; out_valid drops immediately.
- Boundary cases:
  - Wrap-around: 4'hF+4'hF+1 gives sum=4'hF, cout=1.
  - Most-negative case: 4'h8+4'h8 gives sum=0, cout=1, overflow=1.
  - cout and overflow are independent; all four combinations are legal.
- No X propagation from unused states: there is no state machine.

Optional Feature:
- Macro ADDER_STATUS_FLAGS_EN.
- When defined, add these outputs:
  - zero (1): sum==0
  - negative (1): sum[WIDTH-1]
  - zero_q (1): registered zero
  - negative_q (1): registered negative
- zero_q and negative_q follow the same capture, hold and reset rules as sum_q; both reset to 0.
- When not defined, these ports and their logic are absent, and the port list is exactly as listed above.

Decomposition:
- Shared package adder_pkg:
  - ADDER_WIDTH_DEFAULT = 4
  - typedef adder_result_t: a struct of sum, cout, overflow (plus zero and negative under ADDER_STATUS_FLAGS_EN)
- Sub-module fa_cell: 1-bit full adder with ports a, b, cin, s, cout. Instantiate WIDTH times via generate to form the ripple chain.
- The top level holds the flag derivation and the register stage.

Test Plan:
- All cases below run with in_valid=1 and rst_n=1; combinational outputs are checked before each edge, and sum_q/cout_q/overflow_q one cycle later.
- a=0001, b=0001, cin=0 -> sum=0010, cout=0, ovf=0. Same with cin=1 -> sum=0011, cout=0, ovf=0.
- a=0011, b=0101, cin=0 -> sum=1000, cout=0, ovf=1. a=0111, b=0001 -> sum=1000, cout=0, ovf=1.
- a=1111, b=1111, cin=0 -> sum=1110, cout=1, ovf=0. With cin=1 -> sum=1111, cout=1, ovf=0.
- a=1000, b=1000, cin=0 -> sum=0000, cout=1, ovf=1. a=0111, b=1001, cin=0 -> sum=0000, cout=1, ovf=0.
- Register stage:
  - in_valid pulse with a=0011, b=0101 -> next cycle sum_q=1000, overflow_q=1, out_valid=1.
  - in_valid=0 for 3 cycles with changing inputs -> sum_q holds and out_valid=0.
  - rst_n low between edges -> all registered outputs 0 immediately.
- Exhaustive sweep of all 512 a/b/cin combinations against the reference a+b+cin and the sign-based overflow rule. With ADDER_STATUS_FLAGS_EN, a=0111, b=1001 gives zero=1, negative=0.
